uart_tx_dev: RTL and testbench

- Memory-mapped serial transmitter on one device slot of the CPU bridge (DEVn_Addr/WD/WE in, DEVn_RD/IRQ out), the same slot interface the timers use.
- CPU writes bytes into a small FIFO. An 8N1 framer shifts them out on a single tx line.
- A level IRQ tells the CPU that the transmitter has drained.

---
 rtl/uart_tx_dev_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx_dev.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_dev_pkg.sv
// Shared constants for the uart_tx_dev slot: register offsets, STATUS bit positions
// and framer state encodings.
package uart_tx_dev_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int unsigned STAT_EMPTY = 4;
    localparam int unsigned STAT_FULL  = 5;
    localparam int unsigned STAT_BUSY  = 6;
    localparam int unsigned STAT_OVF   = 7;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO; pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 serial transmitter: register decode, byte FIFO, framer and drain IRQ.
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic             wr_data;
    logic             wr_ctrl;
    logic             wr_div;
    logic             en_q;
    logic             irq_en_q;
    logic             ovf_q;
    logic [DIV_W-1:0] div_q;
    logic             irq_q;
    logic             tx_q;
    logic             tx_d;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      count_ext;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] baud_load;
    logic             baud_done;
    logic             busy;
    logic             unused_bits;

    assign wr_data = WE && (Addr[3:2] == REG_DATA);
    assign wr_ctrl = WE && (Addr[3:2] == REG_CTRL);
    assign wr_div  = WE && (Addr[3:2] == REG_DIV);

    assign unused_bits = ^{Addr[31:4], Din};

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_data),
        .push_data (Din[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_W'(DIV_RESET);
        end else begin
            if (wr_ctrl) begin
                en_q     <= Din[CTRL_EN];
                irq_en_q <= Din[CTRL_IRQ_EN];
                ovf_q    <= 1'b0;
            end else if (wr_data && fifo_full) begin
                ovf_q <= 1'b1;
            end
            if (wr_div) begin
                div_q <= Din[DIV_W-1:0];
            end
        end
    end

    // A zero divisor would stall the baud counter, so it behaves as one cycle per bit.
    assign eff_div   = (div_q == '0) ? DIV_W'(1) : div_q;
    assign baud_load = eff_div - DIV_W'(1);
    assign baud_done = (baud_q == '0);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = baud_load;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = baud_load;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = baud_load;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (en_q && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        baud_d   = baud_load;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_en_q & fifo_empty & ~busy;
        end
    end

    assign tx  = tx_q;
    assign IRQ = irq_q;

    assign count_ext = 32'(fifo_count);

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            REG_STATUS: begin
                Dout[3:0]        = count_ext[3:0];
                Dout[STAT_EMPTY] = fifo_empty;
                Dout[STAT_FULL]  = fifo_full;
                Dout[STAT_BUSY]  = busy;
                Dout[STAT_OVF]   = ovf_q;
            end
            REG_CTRL: begin
                Dout[CTRL_EN]     = en_q;
                Dout[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_DIV: Dout[DIV_W-1:0] = div_q;
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx_dev;
    import uart_tx_dev_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    int       n_vec = 0;
    int       n_err = 0;
    int       mon_div = 16;
    bit       expect_b2b = 1'b0;
    bit       mon_busy = 1'b0;
    bit       m_ovf = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = {28'($urandom), a};
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'($urandom), a};
        #1;
        d = Dout;
    endtask

    // Model FIFO: accepted bytes are exactly the bytes that must later appear on the line.
    task automatic push_byte(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovf = 1'b1;
        wr(REG_DATA, {24'($urandom), b});
    endtask

    function automatic logic [31:0] exp_status(input bit busy);
        int c;
        c = exp_q.size();
        return 32'(c) | ((c == 0) ? 32'h10 : 32'h0) | ((c == DEPTH) ? 32'h20 : 32'h0)
             | (busy ? 32'h40 : 32'h0) | (m_ovf ? 32'h80 : 32'h0);
    endfunction

    task automatic wait_drain(input string name);
        logic [31:0] s;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #2;
            rd(REG_STATUS, s);
            if (exp_q.size() == 0 && !mon_busy && s[6] == 1'b0 && s[4] == 1'b1) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // Samples one frame on falling clock edges; the first start-bit sample is already taken.
    task automatic run_frame(output bit finished);
        logic [9:0] bits;
        logic [7:0] want;
        bit clean;
        bit have;
        int d;
        finished = 1'b0;
        clean    = 1'b1;
        have     = 1'b0;
        want     = 8'h00;
        bits     = '0;
        d        = mon_div;
        mon_busy = 1'b1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            have = 1'b1;
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: start bit with no byte pending at %0t", $time);
        end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < d; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (reset !== 1'b1) begin
                    mon_busy = 1'b0;
                    return;
                end
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) clean = 1'b0;
            end
        end
        if (have) check("frame_byte", 32'(bits[8:1]), 32'(want));
        check("frame_shape", {29'b0, clean, bits[0], bits[9]}, 32'b101);
        mon_busy = 1'b0;
        finished = 1'b1;
    endtask

    initial begin : monitor
        bit prev_end;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_end && expect_b2b && exp_q.size() > 0 && reset === 1'b1)
                check("b2b_gap", 32'(tx), 32'd0);
            prev_end = 1'b0;
            if (reset === 1'b1 && tx === 1'b0) run_frame(prev_end);
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] s;
        int k;
        int d;
        int n;

        reset = 1'b0;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_held", 32'(tx), 32'd1);
        check("rst_irq_held", 32'(IRQ), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        rd(REG_STATUS, s); check("rst_status", s, exp_status(0));
        rd(REG_CTRL, s);   check("rst_ctrl", s, 32'h0);
        rd(REG_DIV, s);    check("rst_div", s, 32'd16);
        rd(REG_DATA, s);   check("rst_data_rd", s, 32'h0);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(IRQ), 32'd0);

        // Single byte, divisor 4.
        wr(REG_DIV, 32'd4);
        mon_div = 4;
        wr(REG_CTRL, 32'h1);
        push_byte(8'hA5);
        @(negedge clk); check("lat_before", 32'(tx), 32'd1);
        @(negedge clk); check("lat_fall", 32'(tx), 32'd0);
        repeat (39) @(posedge clk);
        #2;
        rd(REG_STATUS, s); check("busy_last_cycle", 32'(s[6]), 32'd1);
        @(posedge clk);
        #2;
        rd(REG_STATUS, s); check("busy_clear", s, exp_status(0));

        // Back-to-back frames from a preloaded FIFO.
        wait_drain("drain_single");
        wr(REG_DIV, 32'd2);
        mon_div = 2;
        wr(REG_CTRL, 32'h0);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        expect_b2b = 1'b1;
        wr(REG_CTRL, 32'h1);
        rd(REG_STATUS, s); check("b2b_count3", 32'(s[3:0]), 32'd3);
        @(posedge clk);
        #2;
        rd(REG_STATUS, s); check("b2b_count2", 32'(s[3:0]), 32'd2);
        repeat (20) @(posedge clk);
        #2;
        rd(REG_STATUS, s); check("b2b_count1", 32'(s[3:0]), 32'd1);
        repeat (20) @(posedge clk);
        #2;
        rd(REG_STATUS, s); check("b2b_count0", 32'(s[3:0]), 32'd0);
        wait_drain("drain_b2b");
        expect_b2b = 1'b0;

        // Overflow with the framer disabled.
        wr(REG_CTRL, 32'h0);
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        rd(REG_STATUS, s); check("ovf_status", s, exp_status(0));
        wr(REG_STATUS, 32'hFFFF_FFFF);
        rd(REG_STATUS, s); check("status_wr_ignored", s, exp_status(0));
        wr(REG_CTRL, 32'h0);
        m_ovf = 1'b0;
        rd(REG_STATUS, s); check("ovf_cleared", s, exp_status(0));
        rd(REG_CTRL, s);   check("ovf_ctrl", s, 32'h0);
        expect_b2b = 1'b1;
        wr(REG_CTRL, 32'h1);
        wait_drain("drain_ovf");
        expect_b2b = 1'b0;

        // IRQ timing with divisor 1.
        wr(REG_DIV, 32'd1);
        mon_div = 1;
        wr(REG_CTRL, 32'h3);
        @(posedge clk);
        #2;
        check("irq_idle", 32'(IRQ), 32'd1);
        push_byte(8'hFF);
        check("irq_hold", 32'(IRQ), 32'd1);
        @(posedge clk);
        #2;
        check("irq_drop", 32'(IRQ), 32'd0);
        k = -1;
        for (int i = 2; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (IRQ === 1'b1) begin
                k = i;
                break;
            end
        end
        check("irq_rise_edge", 32'(k), 32'd12);
        wr(REG_CTRL, 32'h1);
        check("irq_hold_clr", 32'(IRQ), 32'd1);
        @(posedge clk);
        #2;
        check("irq_clear", 32'(IRQ), 32'd0);

        // Randomized rounds; the first uses divisor 0.
        for (int r = 0; r < 7; r++) begin
            d = (r == 0) ? 0 : int'($urandom_range(1, 5));
            n = int'($urandom_range(1, 4));
            wait_drain("drain_pre_rand");
            wr(REG_DIV, 32'(d));
            mon_div = (d == 0) ? 1 : d;
            rd(REG_DIV, s); check("div_readback", s, 32'(d));
            for (int i = 0; i < n; i++) begin
                push_byte(8'($urandom));
                repeat ($urandom_range(0, 12)) @(posedge clk);
            end
            wait_drain("drain_rand");
        end
        rd(REG_STATUS, s); check("rand_status", s, exp_status(0));

        // Reset during data bit 3 with a second byte still queued.
        wr(REG_DIV, 32'd4);
        mon_div = 4;
        wr(REG_CTRL, 32'h0);
        push_byte(8'h3C);
        push_byte(8'h5A);
        wr(REG_CTRL, 32'h1);
        repeat (18) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_irq", 32'(IRQ), 32'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #2;
        rd(REG_STATUS, s); check("midrst_status", s, exp_status(0));
        rd(REG_DIV, s);    check("midrst_div", s, 32'd16);
        wr(REG_CTRL, 32'h1);
        repeat (60) @(posedge clk);
        #2;
        rd(REG_STATUS, s); check("midrst_no_residual", s, exp_status(0));
        check("midrst_tx_idle", 32'(tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
